// File: rtl/relu_maxpool.sv
// ReLU + 2x2 stride-2 max pooling over a captured, flattened 16-bit result map.
// One input element is examined per cycle; one pooled slot is written per window.
module relu_maxpool #(
  parameter int IN_SIZE  = 7,
  parameter int POOL     = 2,
  parameter int POOL_OUT = IN_SIZE / POOL
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [IN_SIZE*IN_SIZE*16-1:0]    data_in,
  output logic [POOL_OUT*POOL_OUT*16-1:0]  pooled,
  output logic                             busy,
  output logic                             done
);

  localparam int W  = IN_SIZE * IN_SIZE * 16;
  localparam int PW = POOL_OUT * POOL_OUT * 16;
  localparam int KW = (POOL * POOL > 1) ? $clog2(POOL * POOL) : 1;
  localparam int CW = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;

  localparam logic [KW-1:0] KLast = KW'(POOL * POOL - 1);
  localparam logic [CW-1:0] CLast = CW'(POOL_OUT - 1);

  typedef enum logic [1:0] {StIdle, StScan, StStore, StDone} state_t;

  state_t          state_q;
  logic [W-1:0]    snap_q;
  logic [15:0]     max_q;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   wi_q;
  logic [CW-1:0]   wj_q;
  logic [PW-1:0]   pooled_q;
  logic            busy_q;
  logic            done_q;

  int              row;
  int              col;
  int              idx;
  int              slot;
  logic [15:0]     elem;

  // Address of the element under scan and of the output slot of the current window.
  always_comb begin
    row  = int'(wi_q) * POOL + int'(k_q) / POOL;
    col  = int'(wj_q) * POOL + int'(k_q) % POOL;
    idx  = row * IN_SIZE + col;
    slot = int'(wi_q) * POOL_OUT + int'(wj_q);
    elem = snap_q[idx*16 +: 16];
  end

  // Control FSM with registered outputs; max starting at 0 makes ReLU implicit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      max_q    <= '0;
      k_q      <= '0;
      wi_q     <= '0;
      wj_q     <= '0;
      pooled_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            snap_q  <= data_in;
            max_q   <= '0;
            k_q     <= '0;
            wi_q    <= '0;
            wj_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if ($signed(elem) > $signed(max_q)) max_q <= elem;
          if (k_q == KLast) begin
            k_q     <= '0;
            state_q <= StStore;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StStore: begin
          pooled_q[slot*16 +: 16] <= max_q;
          max_q <= '0;
          if (wj_q == CLast) begin
            wj_q <= '0;
            if (wi_q == CLast) begin
              wi_q    <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              wi_q    <= wi_q + 1'b1;
              state_q <= StScan;
            end
          end else begin
            wj_q    <= wj_q + 1'b1;
            state_q <= StScan;
          end
        end
        StDone: begin
          // Wait for start to drop so a held start yields only one pass.
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pooled = pooled_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool: vector table, random vectors vs. a
// window-max reference model, reset-abort and re-arm sequences.
module tb_relu_maxpool;

  localparam int N  = 7;
  localparam int PO = 3;
  localparam int W  = N * N * 16;
  localparam int PW = PO * PO * 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [PW-1:0] pooled;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  relu_maxpool dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .pooled  (pooled),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  din;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] set_el(input logic [W-1:0] d, input int r, input int c,
                                          input logic [15:0] v);
    logic [W-1:0] t;
    t = d;
    t[(r*N+c)*16 +: 16] = v;
    return t;
  endfunction

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    logic [W-1:0] d;
    d = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) d = set_el(d, r, c, v);
    return d;
  endfunction

  function automatic logic [PW-1:0] fill_out(input logic [15:0] v);
    logic [PW-1:0] p;
    for (int s = 0; s < PO*PO; s++) p[s*16 +: 16] = v;
    return p;
  endfunction

  // Reference: each output is max(0, max of its 2x2 block) with signed values.
  function automatic logic [PW-1:0] model(input logic [W-1:0] d);
    logic [PW-1:0] p;
    int m;
    int v;
    for (int i = 0; i < PO; i++)
      for (int j = 0; j < PO; j++) begin
        m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = int'($signed(d[((2*i+dr)*N + 2*j+dc)*16 +: 16]));
            if (v > m) m = v;
          end
        p[(i*PO+j)*16 +: 16] = 16'(m);
      end
    return p;
  endfunction

  // One full pass; scrambles data_in after capture to prove the snapshot is used.
  task automatic do_pass(input string name, input logic [W-1:0] din, input logic [PW-1:0] exp);
    int cyc;
    data_in = din;
    start   = 1'b1;
    @(posedge clk); #1;
    chk({name, "_busy"}, PW'(busy), PW'(1'b1));
    data_in = {W/32{$urandom}};
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, PW'(cyc), PW'(45));
    chk({name, "_pooled"}, pooled, exp);
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, "_done_fall"}, PW'(done), PW'(1'b0));
  endtask

  initial begin
    int ramp_exp[9] = '{8, 10, 12, 22, 24, 26, 36, 38, 40};
    logic [W-1:0]  d;
    logic [PW-1:0] e;
    logic [15:0]   v;
    int            passes;
    logic          busy_prev;

    // Reset state
    #12;
    chk("reset_pooled", pooled, '0);
    chk("reset_busy", PW'(busy), '0);
    chk("reset_done", PW'(done), '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Vector table
    d = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) d = set_el(d, r, c, 16'(r*N+c));
    tbl[0].din = d;
    for (int s = 0; s < 9; s++) e[s*16 +: 16] = 16'(ramp_exp[s]);
    tbl[0].exp = e;
    tbl[1].din = fill(16'hFFF0);
    tbl[1].exp = fill_out(16'h0000);
    for (int p = 0; p < 4; p++) begin
      d = fill(16'd5);
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          if ((r%2)*2 + (c%2) == p) d = set_el(d, r, c, 16'h7FFF);
      tbl[2+p].din = d;
      tbl[2+p].exp = fill_out(16'h7FFF);
    end
    tbl[6].din = fill(16'h8000);
    tbl[6].exp = fill_out(16'h0000);
    d = fill(16'd1);
    for (int k = 0; k < N; k++) begin
      d = set_el(d, 6, k, 16'h7FFF);
      d = set_el(d, k, 6, 16'h7FFF);
    end
    tbl[7].din = d;
    tbl[7].exp = fill_out(16'd1);
    // 0x8000 alongside small negatives and zero: only zero can win
    d = fill(16'hFFFF);
    d = set_el(d, 0, 0, 16'h8000);
    d = set_el(d, 2, 3, 16'h8000);
    d = set_el(d, 4, 4, 16'h0000);
    tbl[8].din = d;
    tbl[8].exp = fill_out(16'h0000);

    for (int t = 0; t < 9; t++) do_pass($sformatf("vec%0d", t), tbl[t].din, tbl[t].exp);

    // Randomized vectors against the reference model
    for (int t = 0; t < 4; t++) begin
      d = '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          v = 16'($urandom);
          if ($urandom_range(1) == 1) v[15] = 1'b1;
          d = set_el(d, r, c, v);
        end
      do_pass($sformatf("rand%0d", t), d, model(d));
    end

    // Reset mid-scan aborts and clears outputs asynchronously
    data_in = tbl[0].din;
    start   = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_mid_pooled", pooled, '0);
    chk("rst_mid_busy", PW'(busy), '0);
    chk("rst_mid_done", PW'(done), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_pass("after_rst", tbl[7].din, tbl[7].exp);

    // Re-arm: start held 200 cycles gives exactly one pass
    data_in   = tbl[0].din;
    start     = 1'b1;
    passes    = 0;
    busy_prev = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (busy && !busy_prev) passes++;
      busy_prev = busy;
    end
    chk("rearm_passes", PW'(passes), PW'(1));
    chk("rearm_done_held", PW'(done), PW'(1'b1));
    chk("rearm_first", pooled, tbl[0].exp);
    d = fill(16'd3);
    d = set_el(d, 5, 5, 16'h0123);
    data_in = d;
    start   = 1'b0;
    @(posedge clk); #1;
    chk("rearm_done_drop", PW'(done), PW'(1'b0));
    do_pass("rearm_second", d, model(d));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
